// File: rtl/display_page_sched.sv
// display_page_sched: pages four 16-bit debug sources onto a 4-digit
// seven-segment driver, converting each to BCD with a serial double-dabble.
module display_page_sched #(
    parameter int unsigned DWELL = 100_000_000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic [15:0] src3,
    input  logic [3:0]  src_en,
    input  logic        hold,
    input  logic        force_vld,
    input  logic [1:0]  force_sel,
    output logic [3:0]  dig0,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic [1:0]  page,
    output logic        ovf,
    output logic        upd
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_dwell;
    logic [1:0]    r_page;
    logic [15:0]   r_bin;
    logic [19:0]   r_bcd;
    logic [3:0]    r_iter;
    logic          r_blank;
    logic [3:0]    r_dig0;
    logic [3:0]    r_dig1;
    logic [3:0]    r_dig2;
    logic [3:0]    r_dig3;
    logic          r_ovf;
    logic          r_upd;

    logic          w_expire;
    logic          w_any_en;
    logic          w_cur_off;
    logic [1:0]    w_page_nxt;
    logic [1:0]    w_load_page;
    logic [15:0]   w_src_sel;
    logic [19:0]   w_bcd_adj;

    // Closest enabled index after p (cyclic); p itself if no other is enabled.
    function automatic logic [1:0] next_en(input logic [1:0] p,
                                           input logic [3:0] en);
        logic [1:0] res;
        res = p;
        for (int k = 3; k >= 1; k--) begin
            if (en[p + 2'(k)]) begin
                res = p + 2'(k);
            end
        end
        return res;
    endfunction

    assign w_expire    = !hold && (r_dwell == CW'(DWELL - 1));
    assign w_any_en    = (src_en != 4'b0000);
    assign w_cur_off   = !src_en[r_page];
    assign w_page_nxt  = next_en(r_page, src_en);
    assign w_load_page = w_cur_off ? w_page_nxt : r_page;

    // Source mux for the page that LOAD will actually capture.
    always_comb begin
        w_src_sel = src0;
        case (w_load_page)
            2'd0:    w_src_sel = src0;
            2'd1:    w_src_sel = src1;
            2'd2:    w_src_sel = src2;
            default: w_src_sel = src3;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; a forced page select restarts the loop at LOAD.
    always_comb begin
        w_state_nxt = r_state;
        if (force_vld) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:   w_state_nxt = S_CONV;
                S_CONV:   w_state_nxt = (r_iter == 4'd15) ? S_COMMIT : S_CONV;
                S_COMMIT: w_state_nxt = S_LOAD;
                default:  w_state_nxt = S_LOAD;
            endcase
        end
    end

    // Dwell counter: frozen by hold, cleared by a forced select.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dwell <= '0;
        end else if (force_vld) begin
            r_dwell <= '0;
        end else if (!hold) begin
            r_dwell <= w_expire ? '0 : r_dwell + CW'(1);
        end
    end

    // Page index: force wins, then dwell expiry, then skipping a disabled page.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_page <= 2'd0;
        end else if (force_vld) begin
            r_page <= force_sel;
        end else if (w_expire) begin
            r_page <= w_page_nxt;
        end else if (r_state == S_LOAD && w_any_en && w_cur_off) begin
            r_page <= w_page_nxt;
        end
    end

    // Conversion datapath: capture at LOAD, shift 16 times in CONV.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_blank <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_bin   <= w_any_en ? w_src_sel : 16'd0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_blank <= !w_any_en;
        end else if (r_state == S_CONV) begin
            {r_bcd, r_bin} <= {w_bcd_adj[18:0], r_bin, 1'b0};
            r_iter         <= r_iter + 4'd1;
        end
    end

    // Output registers: only a completed, non-aborted conversion is shown.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dig0 <= 4'hF;
            r_dig1 <= 4'hF;
            r_dig2 <= 4'hF;
            r_dig3 <= 4'hF;
            r_ovf  <= 1'b0;
            r_upd  <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (r_state == S_COMMIT && !force_vld) begin
                r_dig0 <= r_blank ? 4'hF : r_bcd[15:12];
                r_dig1 <= r_blank ? 4'hF : r_bcd[11:8];
                r_dig2 <= r_blank ? 4'hF : r_bcd[7:4];
                r_dig3 <= r_blank ? 4'hF : r_bcd[3:0];
                r_ovf  <= !r_blank && (r_bcd[19:16] != 4'd0);
                r_upd  <= 1'b1;
            end
        end
    end

    assign dig0 = r_dig0;
    assign dig1 = r_dig1;
    assign dig2 = r_dig2;
    assign dig3 = r_dig3;
    assign page = r_page;
    assign ovf  = r_ovf;
    assign upd  = r_upd;

endmodule

// File: tb/tb_display_page_sched.sv
// tb_display_page_sched: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-count based behavioural model.
module tb_display_page_sched;

    localparam int DWELL = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [15:0] src0 = '0;
    logic [15:0] src1 = '0;
    logic [15:0] src2 = '0;
    logic [15:0] src3 = '0;
    logic [3:0]  src_en = 4'b0001;
    logic        hold = 1'b0;
    logic        force_vld = 1'b0;
    logic [1:0]  force_sel = 2'd0;
    logic [3:0]  dig0, dig1, dig2, dig3;
    logic [1:0]  page;
    logic        ovf, upd;

    int errs = 0;
    int n_chk = 0;
    bit chk_en = 0;

    display_page_sched #(.DWELL(DWELL)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .src_en(src_en), .hold(hold),
        .force_vld(force_vld), .force_sel(force_sel),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .page(page), .ovf(ovf), .upd(upd)
    );

    always #5 CLK = ~CLK;

    // Model: the display update loop is an 18-cycle schedule indexed by phase.
    int         m_page, m_dwell, m_phase, m_val;
    bit         m_blank, m_ovf, m_upd;
    logic [3:0] m_d [4];

    function automatic int m_nxt(int p, logic [3:0] en);
        for (int k = 1; k < 4; k++)
            if (en[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    function automatic int m_src(int p);
        case (p)
            0: return int'(src0);
            1: return int'(src1);
            2: return int'(src2);
            default: return int'(src3);
        endcase
    endfunction

    task automatic m_reset();
        m_page = 0; m_dwell = 0; m_phase = 0; m_val = 0;
        m_blank = 0; m_ovf = 0; m_upd = 0;
        for (int i = 0; i < 4; i++) m_d[i] = 4'hF;
    endtask

    task automatic m_step();
        int  p_old, v;
        bit  expire, ph0;
        p_old  = m_page;
        expire = !hold && (m_dwell == DWELL - 1);
        ph0    = (m_phase == 0);
        m_upd  = 0;
        if (force_vld) begin
            m_page = int'(force_sel);
            m_dwell = 0;
            m_phase = 0;
        end else begin
            if (ph0) begin
                if (src_en == 0) begin
                    m_val = 0; m_blank = 1;
                end else begin
                    m_val = m_src(src_en[p_old] ? p_old : m_nxt(p_old, src_en));
                    m_blank = 0;
                end
            end else if (m_phase == 17) begin
                v = m_val % 10000;
                m_d[0] = m_blank ? 4'hF : 4'(v / 1000);
                m_d[1] = m_blank ? 4'hF : 4'((v / 100) % 10);
                m_d[2] = m_blank ? 4'hF : 4'((v / 10) % 10);
                m_d[3] = m_blank ? 4'hF : 4'(v % 10);
                m_ovf  = !m_blank && (m_val > 9999);
                m_upd  = 1;
            end
            m_phase = (m_phase + 1) % 18;
            if (expire || (ph0 && src_en != 0 && !src_en[p_old]))
                m_page = m_nxt(p_old, src_en);
            if (!hold) m_dwell = (m_dwell + 1) % DWELL;
        end
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) m_reset();
        else m_step();
    end

    function automatic logic [31:0] dvec();
        return {12'd0, dig0, dig1, dig2, dig3, ovf, upd, page};
    endfunction

    function automatic logic [31:0] mvec();
        return {12'd0, m_d[0], m_d[1], m_d[2], m_d[3], m_ovf, m_upd, 2'(m_page)};
    endfunction

    function automatic logic [31:0] lv(int a, int b, int c, int d,
                                       bit o, bit u, int p);
        return {12'd0, 4'(a), 4'(b), 4'(c), 4'(d), o, u, 2'(p)};
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            n_chk++;
            if (dvec() !== mvec()) begin
                errs++;
                $display("FAIL cycle_cmp t=%0t dut=%h model=%h",
                         $time, dvec(), mvec());
            end
        end
    end

    task automatic lit_chk(input string nm, input logic [31:0] act,
                           input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic wait_upd(input int maxc);
        int c;
        c = 0;
        do begin
            @(posedge CLK); #2;
            c++;
        end while (!upd && c < maxc);
        n_chk++;
        if (!upd) begin
            errs++;
            $display("FAIL upd_timeout t=%0t got=0 expected=1", $time);
        end
    endtask

    initial begin
        int prev, c, bad, p0;
        #3 RST_N = 1'b0;
        #1 chk_en = 1;
        // Basic conversion
        src0 = 16'd1234; src_en = 4'b0001;
        @(negedge CLK); #1;
        lit_chk("reset_dut", dvec(), lv(15, 15, 15, 15, 0, 0, 0));
        lit_chk("reset_model", mvec(), lv(15, 15, 15, 15, 0, 0, 0));
        @(negedge CLK) RST_N = 1'b1;
        repeat (17) @(posedge CLK);
        #2 lit_chk("edge17_blank", dvec(), lv(15, 15, 15, 15, 0, 0, 0));
        @(posedge CLK); #2;
        lit_chk("basic_dut", dvec(), lv(1, 2, 3, 4, 0, 1, 0));
        lit_chk("basic_model", mvec(), lv(1, 2, 3, 4, 0, 1, 0));
        // Overflow then back in range
        src0 = 16'd65535;
        wait_upd(40);
        lit_chk("ovf_dut", dvec(), lv(5, 5, 3, 5, 1, 1, 0));
        lit_chk("ovf_model", mvec(), lv(5, 5, 3, 5, 1, 1, 0));
        src0 = 16'd9999;
        wait_upd(40);
        lit_chk("max4_dut", dvec(), lv(9, 9, 9, 9, 0, 1, 0));
        // Rotation over pages 1 and 3
        src_en = 4'b1010; src1 = 16'd11; src3 = 16'd3333;
        c = 0;
        do begin @(posedge CLK); #2; c++; end
        while (!(page == 2'd1 || page == 2'd3) && c < 40);
        prev = int'(page); c = 0;
        do begin @(posedge CLK); #2; c++; end
        while (int'(page) == prev && c < 12);
        for (int i = 0; i < 3; i++) begin
            prev = int'(page);
            repeat (8) @(posedge CLK);
            #2 lit_chk("rot_page", 32'(page), 32'(prev == 1 ? 3 : 1));
        end
        for (int i = 0; i < 2; i++) begin
            wait_upd(40);
            lit_chk("rot_digits",
                    32'({dig0, dig1, dig2, dig3} == 16'h0011 ||
                        {dig0, dig1, dig2, dig3} == 16'h3333), 32'd1);
        end
        // No enabled source
        src1 = 16'd60000; src3 = 16'd60000;
        wait_upd(40);
        src_en = 4'b0000;
        wait_upd(40);
        wait_upd(40);
        lit_chk("blank_digits", 32'({dig0, dig1, dig2, dig3, ovf}), 32'h1FFFE);
        p0 = int'(page); bad = 0;
        repeat (20) begin
            @(posedge CLK); #2;
            if (int'(page) != p0) bad++;
        end
        lit_chk("blank_page_hold", 32'(bad), 32'd0);
        // Force while holding
        src_en = 4'b1111; src2 = 16'd4321; hold = 1'b1;
        wait_upd(40);
        repeat (5) @(posedge CLK);
        #1 force_vld = 1'b1; force_sel = 2'd2;
        @(posedge CLK);
        #1 force_vld = 1'b0;
        c = 0;
        repeat (17) begin
            @(posedge CLK); #2;
            if (upd) c++;
        end
        lit_chk("force_no_upd", 32'(c), 32'd0);
        @(posedge CLK); #2;
        lit_chk("force_dut", dvec(), lv(4, 3, 2, 1, 0, 1, 2));
        lit_chk("force_model", mvec(), lv(4, 3, 2, 1, 0, 1, 2));
        bad = 0;
        repeat (100) begin
            @(posedge CLK); #2;
            if (page != 2'd2) bad++;
        end
        lit_chk("force_page_hold", 32'(bad), 32'd0);
        // Reset mid-conversion
        src0 = 16'd1234;
        wait_upd(40);
        repeat (4) @(posedge CLK);
        #1 RST_N = 1'b0;
        #1 lit_chk("async_rst", dvec(), lv(15, 15, 15, 15, 0, 0, 0));
        @(negedge CLK) RST_N = 1'b1;
        repeat (18) @(posedge CLK);
        #2 lit_chk("rst_restart", dvec(), lv(1, 2, 3, 4, 0, 1, 0));
        // Randomized traffic
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK); #1;
            src0 = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
            src1 = 16'($urandom);
            src2 = 16'($urandom_range(0, 999));
            src3 = 16'($urandom);
            if ($urandom_range(0, 49) == 0) src_en = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0);
            force_vld = ($urandom_range(0, 19) == 0);
            force_sel = 2'($urandom_range(0, 3));
        end
        @(posedge CLK); #1 force_vld = 1'b0;
        repeat (40) @(posedge CLK);
        @(negedge CLK); #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule
